// File: rtl/ind_pkg.sv
// ind_pkg: result codes, 7-segment glyphs and FSM state encoding for ind_driver.
// rev 1.0
`default_nettype none

package ind_pkg;

  localparam int unsigned CODE_P  = 0;
  localparam int unsigned CODE_M  = 1;
  localparam int unsigned CODE_D0 = 2;
  localparam int unsigned CODE_D  = 4;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CONV = 2'd1;
  localparam state_t ST_LOAD = 2'd2;

  typedef enum logic [1:0] {
    MODE_POS,
    MODE_NEG,
    MODE_ERR,
    MODE_FIX
  } disp_mode_t;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Unlisted codes fall back to the plain positive display
  function automatic disp_mode_t code_to_mode(input int unsigned code);
    case (code)
      CODE_M:  return MODE_NEG;
      CODE_D0: return MODE_ERR;
      CODE_D:  return MODE_FIX;
      default: return MODE_POS;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ind_driver_if.sv
// ind_driver_if: result input and display output bundle of ind_driver.
// rev 1.0
`default_nettype none

interface ind_driver_if #(
  parameter int IND_1   = 11,
  parameter int CONTROL = 3
);
  logic [IND_1-1:0]   ind_1;
  logic [CONTROL-1:0] control;
  logic [4:0]         an;
  logic [6:0]         seg;
  logic               dp;
  logic               busy;

  modport master (output ind_1, output control, input an, input seg, input dp, input busy);
  modport slave  (input ind_1, input control, output an, output seg, output dp, output busy);
endinterface

`default_nettype wire

// File: rtl/ind_driver_bin2bcd.sv
// bin2bcd: sequential shift-add-3 binary to BCD converter, one input bit per cycle.
// rev 1.0
`default_nettype none

module bin2bcd #(
  parameter int BIN_W  = 11,
  parameter int DIGITS = 4
) (
  input  wire logic                  clk_IND,
  input  wire logic                  rst_n_IND,
  input  wire logic                  i_load,
  input  wire logic [BIN_W-1:0]      i_bin,
  output logic                       o_done,
  output logic [4*DIGITS-1:0]        o_bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [CNT_W-1:0]    r_cnt;
  logic [BIN_W-1:0]    r_bin;
  logic [4*DIGITS-1:0] r_bcd;
  logic [4*DIGITS-1:0] w_adj;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? r_bcd[4*gi +: 4] + 4'd3
                                                          : r_bcd[4*gi +: 4];
  end

  always_ff @(posedge clk_IND) begin
    if (!rst_n_IND) begin
      r_cnt <= '0;
      r_bin <= '0;
      r_bcd <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(BIN_W);
      r_bin <= i_bin;
      r_bcd <= '0;
    end else if (r_cnt != '0) begin
      r_bcd <= (w_adj << 1) | (4*DIGITS)'(r_bin[BIN_W-1]);
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // High during the final shift so the consumer can take the result on the next edge
  assign o_done = (r_cnt == CNT_W'(1));
  assign o_bcd  = r_bcd;

endmodule

`default_nettype wire

// File: rtl/ind_driver.sv
// ind_driver: converts an ALU result to BCD and scans it onto five multiplexed 7-segment digits.
// rev 1.0
`default_nettype none

module ind_driver
  import ind_pkg::*;
#(
  parameter int IND_1    = 11,
  parameter int CONTROL  = 3,
  parameter int SCAN_DIV = 50000
) (
  input  wire logic   clk_IND,
  input  wire logic   rst_n_IND,
  ind_driver_if.slave bus
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t             r_state;
  logic [IND_1-1:0]   r_cap_val;
  logic [CONTROL-1:0] r_cap_code;
  logic [15:0]        r_disp_bcd;
  logic [CONTROL-1:0] r_disp_code;
  logic               r_busy;
  logic [PRE_W-1:0]   r_pre;
  logic [2:0]         r_idx;
  logic [4:0]         r_an;
  logic [6:0]         r_seg;
  logic               r_dp;

  logic               w_change;
  logic               w_load;
  logic               w_conv_done;
  logic [15:0]        w_bcd;
  disp_mode_t         w_mode;
  logic [4:0]         w_show_dec;
  logic [4:0]         w_show_fix;
  logic [3:0]         w_nib;
  logic [6:0]         w_glyph;
  logic [6:0]         w_seg;
  logic               w_dp;

  assign w_change = {bus.control, bus.ind_1} != {r_cap_code, r_cap_val};
  assign w_load   = (r_state == ST_IDLE) && w_change;

  bin2bcd #(
    .BIN_W  (IND_1),
    .DIGITS (4)
  ) u_bin2bcd (
    .clk_IND   (clk_IND),
    .rst_n_IND (rst_n_IND),
    .i_load    (w_load),
    .i_bin     (bus.ind_1),
    .o_done    (w_conv_done),
    .o_bcd     (w_bcd)
  );

  always_ff @(posedge clk_IND) begin
    if (!rst_n_IND) begin
      r_state     <= ST_IDLE;
      r_cap_val   <= '0;
      r_cap_code  <= '0;
      r_disp_bcd  <= '0;
      r_disp_code <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_change) begin
            r_cap_val  <= bus.ind_1;
            r_cap_code <= bus.control;
            r_busy     <= 1'b1;
            r_state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (w_conv_done) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_disp_bcd  <= w_bcd;
          r_disp_code <= r_cap_code;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_IND) begin
    if (!rst_n_IND) begin
      r_pre <= '0;
      r_idx <= 3'd0;
    end else if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
      r_pre <= '0;
      r_idx <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign w_mode     = code_to_mode(32'(r_disp_code));
  // Leading-zero blanking: a position shows if it or any higher digit is nonzero
  assign w_show_dec = {1'b0, |r_disp_bcd[15:12], |r_disp_bcd[15:8], |r_disp_bcd[15:4], 1'b1};
  assign w_show_fix = {1'b0, |r_disp_bcd[15:12], 3'b111};
  assign w_glyph    = digit_glyph(w_nib);

  always_comb begin
    w_nib = 4'd0;
    case (r_idx)
      3'd0:    w_nib = r_disp_bcd[3:0];
      3'd1:    w_nib = r_disp_bcd[7:4];
      3'd2:    w_nib = r_disp_bcd[11:8];
      3'd3:    w_nib = r_disp_bcd[15:12];
      default: w_nib = 4'd0;
    endcase
  end

  always_comb begin
    w_seg = SEG_BLANK;
    w_dp  = 1'b1;
    case (w_mode)
      MODE_ERR: begin
        case (r_idx)
          3'd0, 3'd1: w_seg = SEG_R;
          3'd2:       w_seg = SEG_E;
          default:    w_seg = SEG_BLANK;
        endcase
      end
      MODE_FIX: begin
        if (w_show_fix[r_idx]) begin
          w_seg = w_glyph;
        end
        w_dp = (r_idx != 3'd2);
      end
      default: begin
        if (w_show_dec[r_idx]) begin
          w_seg = w_glyph;
        end else if ((r_idx == 3'd4) && (w_mode == MODE_NEG)) begin
          w_seg = SEG_MINUS;
        end
      end
    endcase
  end

  always_ff @(posedge clk_IND) begin
    if (!rst_n_IND) begin
      r_an  <= 5'b11111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(5'b00001 << r_idx);
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign bus.an   = r_an;
  assign bus.seg  = r_seg;
  assign bus.dp   = r_dp;
  assign bus.busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_ind_driver.sv
// tb_ind_driver: directed checks of conversion latency, display formats, scan order and reset.
// rev 1.0
`default_nettype none

module tb_ind_driver;

  localparam int SCAN_DIV = 4;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GB = 7'b1111111;
  localparam logic [6:0] GM = 7'b0111111;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GR = 7'b0101111;

  logic clk_IND   = 1'b0;
  logic rst_n_IND = 1'b0;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  ind_driver_if #(.IND_1(11), .CONTROL(3)) bus ();

  ind_driver #(
    .IND_1    (11),
    .CONTROL  (3),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk_IND   (clk_IND),
    .rst_n_IND (rst_n_IND),
    .bus       (bus)
  );

  always #5 clk_IND = ~clk_IND;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // busy is assumed high at the current sample; counts samples until it drops
  task automatic measure_busy(input string tag, input int exp);
    int n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk_IND);
    end
    chk(tag, n, exp);
  endtask

  // glyphs = {pos4,pos3,pos2,pos1,pos0}; dps likewise (bit per position)
  task automatic check_scan(input string tag, input logic [34:0] glyphs,
                            input logic [4:0] dps, input int nsamp);
    int prev = -1;
    int dwell = 0;
    bit seen_change = 0;
    for (int i = 0; i < nsamp; i++) begin
      int p = -1;
      int ones = 0;
      for (int k = 0; k < 5; k++) begin
        if (bus.an[k] === 1'b0) begin
          p = k;
          ones++;
        end
      end
      chk({tag, "_an_onehot"}, ones, 1);
      if (ones == 1) begin
        if (prev >= 0 && p != prev) begin
          chk({tag, "_order"}, p, (prev + 1) % 5);
          if (seen_change) chk({tag, "_dwell"}, dwell, SCAN_DIV);
          seen_change = 1;
          dwell = 1;
        end else begin
          dwell++;
        end
        prev = p;
        chk($sformatf("%s_seg%0d", tag, p), bus.seg, glyphs[7*p +: 7]);
        chk($sformatf("%s_dp%0d", tag, p), bus.dp, dps[p]);
      end
      @(negedge clk_IND);
    end
  endtask

  task automatic start_conv(input string tag, input logic [10:0] v, input logic [2:0] c);
    bus.ind_1   = v;
    bus.control = c;
    @(negedge clk_IND);
    chk({tag, "_busy_rise"}, bus.busy, 1'b1);
    measure_busy({tag, "_busy_len"}, 12);
    @(negedge clk_IND);
  endtask

  initial begin
    bus.ind_1   = '0;
    bus.control = '0;
    repeat (2) @(negedge clk_IND);
    chk("rst_an", bus.an, 5'b11111);
    chk("rst_seg", bus.seg, 7'b1111111);
    chk("rst_dp", bus.dp, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);

    rst_n_IND = 1'b1;
    @(negedge clk_IND);
    chk("idle_busy", bus.busy, 1'b0);
    check_scan("zero", {GB, GB, GB, GB, G0}, 5'b11111, 20);

    start_conv("d1234", 11'd1234, 3'd0);
    check_scan("d1234", {GB, G1, G2, G3, G4}, 5'b11111, 20);

    start_conv("c3", 11'd42, 3'd3);
    check_scan("c3", {GB, GB, GB, G4, G2}, 5'b11111, 20);

    start_conv("neg7", 11'd7, 3'd1);
    check_scan("neg7", {GM, GB, GB, GB, G7}, 5'b11111, 20);

    start_conv("fix5", 11'd5, 3'd4);
    check_scan("fix5", {GB, GB, G0, G0, G5}, 5'b11011, 20);

    start_conv("err", 11'd5, 3'd2);
    check_scan("err", {GB, GB, GE, GR, GR}, 5'b11111, 20);
    start_conv("err2", 11'd100, 3'd2);
    check_scan("err2", {GB, GB, GE, GR, GR}, 5'b11111, 20);

    // 9 arrives mid-conversion and must wait for the next IDLE cycle
    bus.ind_1   = 11'd2047;
    bus.control = 3'd0;
    @(negedge clk_IND);
    chk("d2047_busy_rise", bus.busy, 1'b1);
    repeat (2) @(negedge clk_IND);
    bus.ind_1 = 11'd9;
    measure_busy("d2047_busy_len", 10);
    @(negedge clk_IND);
    chk("d9_restart", bus.busy, 1'b1);
    check_scan("d2047", {GB, G2, G0, G4, G7}, 5'b11111, 10);
    measure_busy("d9_busy_rest", 2);
    @(negedge clk_IND);
    check_scan("d9", {GB, GB, GB, GB, G9}, 5'b11111, 20);

    bus.ind_1   = 11'd1234;
    bus.control = 3'd0;
    @(negedge clk_IND);
    chk("abort_busy_rise", bus.busy, 1'b1);
    repeat (4) @(negedge clk_IND);
    rst_n_IND   = 1'b0;
    bus.ind_1   = '0;
    @(negedge clk_IND);
    chk("abort_an", bus.an, 5'b11111);
    chk("abort_seg", bus.seg, 7'b1111111);
    chk("abort_dp", bus.dp, 1'b1);
    chk("abort_busy", bus.busy, 1'b0);
    rst_n_IND = 1'b1;
    @(negedge clk_IND);
    chk("abort_idle1", bus.busy, 1'b0);
    repeat (2) @(negedge clk_IND);
    chk("abort_idle2", bus.busy, 1'b0);
    check_scan("abort", {GB, GB, GB, GB, G0}, 5'b11111, 20);

    rst_n_IND = 1'b0;
    bus.ind_1 = 11'd3;
    @(negedge clk_IND);
    chk("rst2_busy", bus.busy, 1'b0);
    rst_n_IND = 1'b1;
    @(negedge clk_IND);
    chk("post_rst_busy", bus.busy, 1'b1);
    measure_busy("post_rst_len", 12);
    @(negedge clk_IND);
    check_scan("post_rst", {GB, GB, GB, GB, G3}, 5'b11111, 20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
